uart_tx_fifo: RTL and testbench

- Byte FIFO sitting directly upstream of the UART transmitter.
- Accepts characters from the frame/character generator over a valid/ready write port.
- Drains them into the transmitter's start/data_in/txe interface, so the producer never stalls on per-byte UART timing.
- Provides fill level, a sticky overflow flag and a synchronous flush.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_tx_fifo.sv | 78 +++++++
 tb/tb_uart_tx_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART transmit path
package uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int UART_FIFO_DEPTH_LOG2 = 4;

    typedef logic [BYTE_W-1:0] uart_byte_t;

    // Control characters emitted by the frame/character generator
    localparam uart_byte_t ASCII_CR  = 8'h0D;
    localparam uart_byte_t ASCII_LF  = 8'h0A;
    localparam uart_byte_t ASCII_ESC = 8'h1B;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register array with synchronous write and asynchronous read
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_FIFO_DEPTH_LOG2,
    parameter int DATA_W = BYTE_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are not reset; only the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART transmitter start/data_in/txe port
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_txe,
    output logic [DEPTH_LOG2:0] level,
    output logic              empty,
    output logic              overflow
);

    localparam int PW = DEPTH_LOG2 + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;

    // The extra MSB on each pointer tells a full FIFO apart from an empty one
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    // Flags come only from registered pointers, so there is no path from
    // tx_txe to wr_ready or from wr_valid to tx_start
    assign wr_ready = !full;
    assign tx_start = !empty;

    assign push = wr_valid && wr_ready;
    assign pop  = tx_start && tx_txe;

    uart_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (tx_data)
    );

    // Pointer and sticky overflow update; flush wins over push and pop
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a serial transmitter model
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       nrst;
    logic       flush;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_txe;
    logic [4:0] level;
    logic       empty;
    logic       overflow;

    logic       tb_txe;
    logic       use_model;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_txe   (tx_txe),
        .level    (level),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Transmitter model: one shift register plus a one-byte holding buffer, 2 clocks per bit
    logic       m_busy, m_hold_full, m_div, m_txe, m_txd;
    logic [7:0] m_hold;
    logic [9:0] m_frame;
    logic [3:0] m_bitn;
    wire        m_accept = use_model && tx_start && tx_txe;
    wire        m_done   = m_busy && m_div && (m_bitn == 4'd9);
    wire        m_free   = !m_busy || m_done;

    assign m_txe  = !m_hold_full;
    assign m_txd  = m_busy ? m_frame[0] : 1'b1;
    assign tx_txe = use_model ? m_txe : tb_txe;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy <= 1'b0; m_hold_full <= 1'b0; m_div <= 1'b0;
            m_bitn <= 4'd0; m_frame <= 10'h3FF; m_hold <= 8'h00;
        end else begin
            if (m_busy) begin
                m_div <= !m_div;
                if (m_div) begin
                    if (m_bitn == 4'd9) m_busy <= 1'b0;
                    else begin
                        m_bitn  <= m_bitn + 4'd1;
                        m_frame <= {1'b1, m_frame[9:1]};
                    end
                end
            end
            if (m_free && m_hold_full) begin
                m_frame <= {1'b1, m_hold, 1'b0}; m_busy <= 1'b1;
                m_bitn <= 4'd0; m_div <= 1'b0; m_hold_full <= 1'b0;
            end else if (m_free && m_accept) begin
                m_frame <= {1'b1, tx_data, 1'b0}; m_busy <= 1'b1;
                m_bitn <= 4'd0; m_div <= 1'b0;
            end else if (m_accept) begin
                m_hold <= tx_data; m_hold_full <= 1'b1;
            end
        end
    end

    // Serial decoder: start bit found on its first negedge, data sampled on each bit's first negedge
    logic       rx_busy;
    logic [4:0] rx_k;
    logic [7:0] rx_sh;
    int         frame_err = 0;
    int         viol_cnt  = 0;

    always @(negedge clk) begin
        if (!nrst) begin
            rx_busy <= 1'b0;
            rx_k    <= 5'd0;
        end else if (!rx_busy) begin
            if (m_txd == 1'b0) begin
                rx_busy <= 1'b1;
                rx_k    <= 5'd1;
            end
        end else begin
            if (!rx_k[0] && rx_k >= 5'd2 && rx_k <= 5'd16) rx_sh[rx_k[4:1] - 4'd1] <= m_txd;
            if (rx_k == 5'd18) begin
                rx_busy <= 1'b0;
                rx_q.push_back(rx_sh);
                if (m_txd !== 1'b1) frame_err <= frame_err + 1;
            end
            rx_k <= rx_k + 5'd1;
        end
    end

    // Presentation rule monitor: tx_start must track non-empty exactly
    always @(negedge clk) begin
        if (nrst && ((tx_start !== !empty) || (tx_start && level == 5'd0)))
            viol_cnt <= viol_cnt + 1;
    end

    task automatic test_reset();
        tb_txe = 1'b0;
        @(negedge clk); wr_valid = 1'b1; wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge clk); nrst = 1'b1;
    endtask

    task automatic test_single();
        tb_txe = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
        @(negedge clk); wr_valid = 1'b0;
        n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", tx_start); end
        n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level1: got %0d want 1", level); end
        exp = exp_q.pop_front();
        n_tests++; if (tx_data !== exp) begin n_fail++; $display("FAIL single_data: got %h want %h", tx_data, exp); end
        @(negedge clk);
        n_tests++; if (level !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0) begin
            n_fail++; $display("FAIL single_drained: level=%0d empty=%b start=%b want 0/1/0", level, empty, tx_start); end
        tb_txe = 1'b0;
    endtask

    task automatic test_backpressure();
        tb_txe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 1", i, wr_ready); end
            wr_valid = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
            @(negedge clk);
        end
        n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL bp_level_full: got %0d want 16", level); end
        n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", wr_ready); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_early: got %b want 0", overflow); end
        wr_data = 8'hAA;
        @(negedge clk); wr_valid = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
        n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL bp_level_after_ovf: got %0d want 16", level); end
        // full with push and pop together: push refused, head consumed
        wr_valid = 1'b1; wr_data = 8'h55; tb_txe = 1'b1;
        n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fullpp_ready: got %b want 0", wr_ready); end
        exp = exp_q.pop_front();
        n_tests++; if (tx_data !== exp) begin n_fail++; $display("FAIL fullpp_head: got %h want %h", tx_data, exp); end
        @(negedge clk); wr_valid = 1'b0; tb_txe = 1'b0;
        n_tests++; if (level !== 5'd15) begin n_fail++; $display("FAIL fullpp_level: got %0d want 15", level); end
        n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fullpp_ready_after: got %b want 1", wr_ready); end
        tb_txe = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (tx_start) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_tests++; if (tx_data !== exp) begin n_fail++; $display("FAIL bp_drain_order: got %h want %h", tx_data, exp); end
            end
            @(negedge clk);
        end
        tb_txe = 1'b0;
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain_count: %0d bytes left want 0", exp_q.size()); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bp_drain_empty: got %b want 1", empty); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow); end
        exp_q.delete();
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_flush_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_drain();
        logic [7:0] hello [7];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, ASCII_CR, ASCII_LF};
        rx_q.delete();
        use_model = 1'b1;
        viol_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_%0d: got %b want 1", i, wr_ready); end
            wr_valid = 1'b1; wr_data = hello[i]; exp_q.push_back(hello[i]);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        for (int c = 0; c < 800 && rx_q.size() < 7; c++) @(negedge clk);
        repeat (6) @(negedge clk);
        n_tests++; if (rx_q.size() != 7) begin n_fail++; $display("FAIL drain_count: got %0d bytes want 7", rx_q.size()); end
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            n_tests++;
            if (rx_q.size() == 0) begin n_fail++; $display("FAIL drain_byte: got none want %h", exp); end
            else if (rx_q[0] !== exp) begin n_fail++; $display("FAIL drain_byte: got %h want %h", rx_q[0], exp); void'(rx_q.pop_front()); end
            else void'(rx_q.pop_front());
        end
        n_tests++; if (frame_err != 0) begin n_fail++; $display("FAIL drain_stop_bits: %0d bad stop bits want 0", frame_err); end
        n_tests++; if (viol_cnt != 0) begin n_fail++; $display("FAIL drain_start_while_empty: %0d cycles want 0", viol_cnt); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
        use_model = 1'b0;
    endtask

    task automatic test_wrap();
        tb_txe = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL wrap_level_%0d: got %0d want 1", i, level); end
            end
            if (tx_start) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                n_tests++; if (tx_data !== exp) begin n_fail++; $display("FAIL wrap_order: got %h want %h", tx_data, exp); end
            end
            wr_valid = 1'b1; wr_data = 8'(i * 7 + 3); exp_q.push_back(8'(i * 7 + 3));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (tx_start) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_tests++; if (tx_data !== exp) begin n_fail++; $display("FAIL wrap_order_last: got %h want %h", tx_data, exp); end
        end
        @(negedge clk); tb_txe = 1'b0;
        n_tests++; if (exp_q.size() != 0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_done: left=%0d empty=%b want 0/1", exp_q.size(), empty); end
    endtask

    task automatic test_flush();
        tb_txe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h20 + i); exp_q.push_back(8'(8'h20 + i));
            @(negedge clk);
        end
        wr_data = 8'hEE;
        @(negedge clk); wr_valid = 1'b0; tb_txe = 1'b1;
        for (int k = 0; k < 11; k++) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_tests++; if (tx_start !== 1'b1 || tx_data !== exp) begin
                n_fail++; $display("FAIL flush_predrain: start=%b data=%h want 1/%h", tx_start, tx_data, exp); end
            @(negedge clk);
        end
        tb_txe = 1'b0;
        n_tests++; if (level !== 5'd5 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL flush_setup: level=%0d ovf=%b want 5/1", level, overflow); end
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
        @(negedge clk); flush = 1'b0; wr_valid = 1'b0; exp_q.delete();
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", overflow); end
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL flush_start: got %b want 0", tx_start); end
        n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", wr_ready); end
        wr_valid = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
        @(negedge clk); wr_valid = 1'b0; tb_txe = 1'b1;
        exp = exp_q.pop_front();
        n_tests++; if (tx_start !== 1'b1 || tx_data !== exp || level !== 5'd1) begin
            n_fail++; $display("FAIL flush_after_push: start=%b data=%h level=%0d want 1/%h/1", tx_start, tx_data, level, exp); end
        @(negedge clk); tb_txe = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_final_empty: got %b want 1", empty); end
    endtask

    initial begin
        nrst = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        tb_txe = 1'b0; use_model = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_drain();
        test_wrap();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
